rotate_right_seq: RTL and testbench
===================================

Name: rotate_right_seq

Overview:
- Multi-cycle 16-bit right shift/rotate unit for the ALU execute path.
- Counterpart to the single-stage rotate-left-by-4 network: it performs right-direction operations, and rotate-left by complement.
- One stage per cycle, applying amounts 8, 4, 2, 1 over four cycles, with a start/busy/done handshake.
- Result is registered; the pipeline stalls on Busy.

Parameters:
WIDTH, 16, data width; fixed at 16 (4-bit count), other values unsupported.

Ports:
clk   input   1    clock, all state updates on rising edge
rst   input   1    synchronous reset, active-high
Start input   1    request; sampled on rising edge when accepted (see Behaviour)
In    input   16   operand; captured at accepted Start
Cnt   input   4    shift/rotate amount 0..15; captured at accepted Start
Op    input   2    00 rotate right, 01 shift right logical, 10 shift right arithmetic, 11 rotate left; captured at accepted Start
Busy  output  1    high while an operation is in flight
Done  output  1    one-cycle pulse when Out is updated
Out   output  16   result register; holds last completed result

Behaviour:
- Reset:
  - rst=1 at an edge: state->IDLE, Busy=0, Done=0, Out=16'h0000, internal work/count/op registers cleared.
  - Reset overrides Start and any in-flight operation; the aborted result never appears on Out.
- States: IDLE, S8, S4, S2, S1, DONE.
- Start acceptance:
  - Start is accepted only in IDLE or DONE.
  - Start while Busy=1 (S8..S1) is ignored, with no queuing.
- Accepted Start at edge t0:
  - work <= In.
  - amt <= Cnt for Op 00/01/10; amt <= (0 - Cnt) mod 16 for Op 11 (rotate left n == rotate right 16-n).
  - opr <= Op, with 11 stored as rotate-right.
  - state <= S8.
- Stage edges:
  - t1 (S8): if amt[3], work shifted/rotated right by 8.
  - t2 (S4): if amt[2], by 4.
  - t3 (S2): if amt[1], by 2.
  - t4 (S1): if amt[0], by 1; Out <= final work value; state <= DONE.
- Fill rules:
  - Rotate: bits leaving bit 0 re-enter at bit 15.
  - Logical: zero fill.
  - Arithmetic: fill with captured In[15], which work[15] preserves every stage.
- Outputs:
  - Busy=1 in S8, S4, S2, S1; 0 in IDLE and DONE.
  - Done=1 only in DONE, for exactly one cycle.
  - DONE -> S8 if Start, else IDLE.
- Latency: Start accepted at t0 -> Out valid and Done=1 in the cycle after t4 (4 cycles).
- Back-to-back: Start held high in DONE gives throughput of one result per 5 cycles.
- Cnt=0 in any Op, or Op 11 with Cnt=0: Out=In after the full 4-cycle latency.
- Out is unchanged between completions; In/Cnt/Op changes after capture have no effect.
- Fully synchronous, no latches; all outputs driven from registers.

Test Plan:
1. Reset, then Start, Op=00, In=16'h1234, Cnt=4 -> Busy high 4 cycles, then Done pulse with Out=16'h4123.
2. Op=01, In=16'h8000, Cnt=15 -> Out=16'h0001; then Op=10 with the same In/Cnt -> Out=16'hFFFF; Op=10, In=16'h7F00, Cnt=8 -> Out=16'h007F.
3. Op=11, In=16'h1234, Cnt=4 -> Out=16'h2341; Op=11, Cnt=0, In=16'hBEEF -> Out=16'hBEEF; Op=00, Cnt=15, In=16'h0001 -> Out=16'h0002.
4. Start, Op=00, In=16'hA5A5, Cnt=1, then Start pulsed with In=16'hFFFF in S4 -> ignored, Out=16'hD2D2, exactly one Done pulse.
5. Start held high continuously with alternating operands -> new operation accepted in each DONE cycle; Done every 5th cycle with correct Out each time.
6. rst asserted in S2 during Op=01, In=16'hFFFF, Cnt=3 -> next cycle IDLE, Busy=0, Done=0, Out=16'h0000; no Done pulse follows; a subsequent Start completes normally.

Source files
------------

// File: rtl/rotate_right_seq.sv
// Four-stage 16-bit right shift/rotate unit: one binary-weighted stage (8,4,2,1) per cycle.
// Rotate-left is executed as a rotate-right by the two's complement of the count.
module rotate_right_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] In,
   input  logic [3:0]       Cnt,
   input  logic [1:0]       Op,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Out
);
   // state | meaning
   // IDLE  | waiting for Start
   // S8    | apply amt[3] (by 8)
   // S4    | apply amt[2] (by 4)
   // S2    | apply amt[1] (by 2)
   // S1    | apply amt[0] (by 1), load Out
   // DONE  | Done pulse; Start here chains the next operation
   typedef enum logic [2:0] {IDLE, S8, S4, S2, S1, DONE} state_t;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROL = 2'b11;

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [3:0]       amt;
   logic [1:0]       opr;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w,
                                             input logic [1:0] op,
                                             input logic en,
                                             input int k);
      logic [WIDTH-1:0] r;
      r = w;
      if (en) begin
         case (op)
            OP_SRL:  r = w >> k;
            OP_SRA:  r = $signed(w) >>> k;
            default: r = (w >> k) | (w << (WIDTH - k));
         endcase
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         amt   <= '0;
         opr   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         Out   <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  work  <= In;
                  amt   <= (Op == OP_ROL) ? 4'd0 - Cnt : Cnt;
                  opr   <= (Op == OP_ROL) ? OP_ROR : Op;
                  Busy  <= 1'b1;
                  state <= S8;
               end else begin
                  state <= IDLE;
               end
            end
            S8: begin
               work  <= step(work, opr, amt[3], 8);
               state <= S4;
            end
            S4: begin
               work  <= step(work, opr, amt[2], 4);
               state <= S2;
            end
            S2: begin
               work  <= step(work, opr, amt[1], 2);
               state <= S1;
            end
            S1: begin
               work  <= step(work, opr, amt[0], 1);
               Out   <= step(work, opr, amt[0], 1);
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= DONE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rotate_right_seq.sv
// Bench for rotate_right_seq: directed plan cases plus random operations
// compared against a bit-index reference model.
module tb_rotate_right_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Start = 1'b0;
   logic [15:0] In = '0;
   logic [3:0]  Cnt = '0;
   logic [1:0]  Op = '0;
   logic        Busy;
   logic        Done;
   logic [15:0] Out;

   int checks = 0;
   int failures = 0;

   rotate_right_seq dut (
      .clk(clk), .rst(rst), .Start(Start), .In(In), .Cnt(Cnt), .Op(Op),
      .Busy(Busy), .Done(Done), .Out(Out)
   );

   always #5 clk = ~clk;

   // Each output bit i is picked from the source bit it should come from.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] c,
                                         input logic [1:0] o);
      logic [15:0] r;
      int n;
      n = int'(c);
      r = '0;
      for (int i = 0; i < 16; i++) begin
         case (o)
            2'b00: r[i] = a[(i + n) % 16];
            2'b01: r[i] = (i + n < 16) ? a[i + n] : 1'b0;
            2'b10: r[i] = (i + n < 16) ? a[i + n] : a[15];
            default: r[(i + n) % 16] = a[i];
         endcase
      end
      return r;
   endfunction

   task automatic issue(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                        output int busy_n, output logic done_s, output logic [15:0] out_s);
      @(negedge clk);
      Start = 1'b1; In = a; Cnt = c; Op = o;
      @(negedge clk);
      Start = 1'b0; In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
      busy_n = int'(Busy);
      repeat (3) begin
         @(negedge clk);
         busy_n += int'(Busy);
      end
      @(negedge clk);
      busy_n += int'(Busy);
      done_s = Done;
      out_s  = Out;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Out !== 16'h0000) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b out=%h, want 0 0 0000", Busy, Done, Out);
      end
   endtask

   task automatic run_dir(input string name, input logic [15:0] a, input logic [3:0] c,
                          input logic [1:0] o, input logic [15:0] want);
      int b; logic d; logic [15:0] r;
      issue(a, c, o, b, d, r);
      checks++;
      if (b !== 4 || d !== 1'b1 || r !== want) begin
         failures++;
         $display("FAIL %s: busy_cycles=%0d done=%b out=%h, want 4 1 %h", name, b, d, r, want);
      end
      @(negedge clk);
      checks++;
      if (Done !== 1'b0 || Out !== want) begin
         failures++;
         $display("FAIL %s_hold: done=%b out=%h, want 0 %h", name, Done, Out, want);
      end
   endtask

   task automatic test_rotate;
      run_dir("ror_1234_4", 16'h1234, 4'd4, 2'b00, 16'h4123);
   endtask

   task automatic test_shifts;
      run_dir("srl_8000_15", 16'h8000, 4'd15, 2'b01, 16'h0001);
      run_dir("sra_8000_15", 16'h8000, 4'd15, 2'b10, 16'hFFFF);
      run_dir("sra_7f00_8",  16'h7F00, 4'd8,  2'b10, 16'h007F);
   endtask

   task automatic test_rotate_left;
      run_dir("rol_1234_4", 16'h1234, 4'd4,  2'b11, 16'h2341);
      run_dir("rol_beef_0", 16'hBEEF, 4'd0,  2'b11, 16'hBEEF);
      run_dir("ror_0001_15", 16'h0001, 4'd15, 2'b00, 16'h0002);
   endtask

   task automatic test_random;
      int b; logic d; logic [15:0] r, a, want;
      logic [3:0] c; logic [1:0] o;
      for (int k = 0; k < 48; k++) begin
         a = 16'($urandom);
         c = (k < 4) ? 4'd0 : 4'($urandom);
         o = (k < 4) ? 2'(k) : 2'($urandom);
         want = model(a, c, o);
         issue(a, c, o, b, d, r);
         checks++;
         if (b !== 4 || d !== 1'b1 || r !== want) begin
            failures++;
            $display("FAIL random op=%0d in=%h cnt=%0d: busy_cycles=%0d done=%b out=%h, want 4 1 %h",
                     o, a, c, b, d, r, want);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start;
      int dones = 0;
      logic [15:0] got = '0;
      @(negedge clk);
      Start = 1'b1; In = 16'hA5A5; Cnt = 4'd1; Op = 2'b00;
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      Start = 1'b1; In = 16'hFFFF; Cnt = 4'd0; Op = 2'b01;
      @(negedge clk);
      Start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (Done) begin
            dones++;
            got = Out;
         end
      end
      checks++;
      if (dones !== 1 || got !== 16'hD2D2 || Out !== 16'hD2D2) begin
         failures++;
         $display("FAIL ignore_start: dones=%0d out=%h, want 1 d2d2", dones, got);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] q_exp[$];
      logic [15:0] a, exp_v;
      logic [3:0] c; logic [1:0] o;
      int results = 0, cyc = 0, last = -1;
      a = 16'($urandom); c = 4'($urandom); o = 2'($urandom);
      @(negedge clk);
      Start = 1'b1; In = a; Cnt = c; Op = o;
      q_exp.push_back(model(a, c, o));
      while (results < 6 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (Done) begin
            exp_v = q_exp.pop_front();
            checks++;
            if (Out !== exp_v || (last >= 0 && cyc - last !== 5)) begin
               failures++;
               $display("FAIL back_to_back #%0d: out=%h gap=%0d, want %h gap 5",
                        results, Out, cyc - last, exp_v);
            end
            last = cyc;
            results++;
            if (results < 6) begin
               a = (results % 2 == 1) ? ~a : 16'($urandom);
               c = 4'($urandom); o = 2'($urandom);
               In = a; Cnt = c; Op = o;
               q_exp.push_back(model(a, c, o));
            end else begin
               Start = 1'b0;
            end
         end
      end
      Start = 1'b0;
      checks++;
      if (results !== 6) begin
         failures++;
         $display("FAIL back_to_back_timeout: results=%0d, want 6", results);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midway;
      int dones = 0;
      @(negedge clk);
      Start = 1'b1; In = 16'hFFFF; Cnt = 4'd3; Op = 2'b01;
      @(negedge clk);
      Start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_midway: busy=%b done=%b out=%h, want 0 0 0000", Busy, Done, Out);
      end
      repeat (6) begin
         @(negedge clk);
         if (Done || Busy) dones++;
      end
      checks++;
      if (dones !== 0 || Out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_midway_quiet: activity=%0d out=%h, want 0 0000", dones, Out);
      end
      run_dir("after_reset", 16'h00F0, 4'd4, 2'b01, 16'h000F);
   endtask

   initial begin
      test_reset();
      test_rotate();
      test_shifts();
      test_rotate_left();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_midway();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
